// File: rtl/ppm_tx.sv
// rtl/ppm_tx.sv - 2-slot PPM bit serializer: preamble, start bit, 8 data bits MSB first, idle gap
module ppm_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BPS      = 125_000,
  parameter int HALF_CNT = CLK_FREQ / BPS / 2,
  parameter int PRE_LEN  = 8,
  parameter int GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int SW = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(HALF_CNT - 1);
  localparam logic [7:0]    PRE_LAST  = 8'(PRE_LEN - 1);
  localparam logic [7:0]    GAP_LAST  = 8'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_START,
    S_DATA,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic          slot_q, slot_d;
  logic [7:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_out_q, tx_out_d;
  logic          busy_q, busy_d;
  logic          tx_ready_q, tx_ready_d;
  logic          frame_done_q, frame_done_d;
  logic          bit_end;

  // The counters describe the slot currently on the line; outputs are computed
  // from the next position so every output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    slot_d     = slot_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    shreg_d    = shreg_q;
    bit_end    = 1'b0;

    if (state_q == S_IDLE) begin
      if (tx_valid && tx_ready_q) begin
        state_d    = S_PRE;
        slot_cnt_d = '0;
        slot_d     = 1'b0;
        bit_cnt_d  = 8'd0;
        gap_cnt_d  = 8'd0;
        shreg_d    = tx_data;
      end
    end else begin
      if (slot_cnt_q == SLOT_LAST) begin
        slot_cnt_d = '0;
        slot_d     = ~slot_q;
        bit_end    = slot_q;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end

      if (bit_end) begin
        case (state_q)
          S_PRE: begin
            if (bit_cnt_q == PRE_LAST) begin
              state_d   = S_START;
              bit_cnt_d = 8'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 8'd1;
            end
          end
          S_START: begin
            state_d   = S_DATA;
            bit_cnt_d = 8'd0;
          end
          S_DATA: begin
            shreg_d = {shreg_q[6:0], 1'b0};
            if (bit_cnt_q == 8'd7) begin
              state_d   = S_GAP;
              bit_cnt_d = 8'd0;
              gap_cnt_d = 8'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 8'd1;
            end
          end
          S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
              state_d   = S_IDLE;
              gap_cnt_d = 8'd0;
            end else begin
              gap_cnt_d = gap_cnt_q + 8'd1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Line level and status flags for the position the next cycle will hold.
  always_comb begin
    tx_out_d = 1'b0;
    case (state_d)
      S_PRE:   tx_out_d = ~slot_d;
      S_START: tx_out_d = slot_d;
      S_DATA:  tx_out_d = slot_d ? ~shreg_d[7] : shreg_d[7];
      default: tx_out_d = 1'b0;
    endcase
    busy_d       = (state_d != S_IDLE);
    tx_ready_d   = (state_d == S_IDLE);
    frame_done_d = (state_d == S_GAP) && (gap_cnt_d == GAP_LAST) &&
                   slot_d && (slot_cnt_d == SLOT_LAST);
  end

  // State, counters and registered outputs; reset drops the line immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      slot_cnt_q   <= '0;
      slot_q       <= 1'b0;
      bit_cnt_q    <= 8'd0;
      gap_cnt_q    <= 8'd0;
      shreg_q      <= 8'd0;
      tx_out_q     <= 1'b0;
      busy_q       <= 1'b0;
      tx_ready_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      slot_q       <= slot_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shreg_q      <= shreg_d;
      tx_out_q     <= tx_out_d;
      busy_q       <= busy_d;
      tx_ready_q   <= tx_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_out     = tx_out_q;
  assign busy       = busy_q;
  assign tx_ready   = tx_ready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ppm_tx.sv
// tb/tb_ppm_tx.sv - scoreboard bench for ppm_tx with waveform check and PPM receiver model
module tb_ppm_tx;

  localparam int H   = 8;
  localparam int PRE = 4;
  localparam int GAP = 2;
  localparam int BIT = 2 * H;
  localparam int FL  = (PRE + 1 + 8 + GAP) * BIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_out, busy, frame_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frames_seen = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp_q[$];

  ppm_tx #(
    .CLK_FREQ(1600), .BPS(100), .HALF_CNT(H), .PRE_LEN(PRE), .GAP_BITS(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected line level at clock i of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    int   bi;
    logic slot, v;
    bi   = i / BIT;
    slot = (i % BIT) >= H;
    if (bi < PRE) v = 1'b1;
    else if (bi == PRE) v = 1'b0;
    else if (bi < PRE + 9) v = b[7 - (bi - PRE - 1)];
    else return 1'b0;
    return slot ? ~v : v;
  endfunction

  // One frame from its first high clock through the following IDLE cycle.
  task automatic capture();
    logic [7:0] eb, db;
    int wave_bad, busy_bad, fd_cnt, fd_pos, bi;
    wave_bad = 0; busy_bad = 0; fd_cnt = 0; fd_pos = -1; db = 8'd0;
    if (exp_q.size() == 0) begin
      check_eq("extra_frame", 1, 0);
      eb = 8'd0;
    end else begin
      eb = exp_q.pop_front();
    end
    for (int i = 0; i < FL; i++) begin
      if (i > 0) @(negedge clk);
      if (tx_out !== exp_bit(eb, i)) wave_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (frame_done === 1'b1) begin fd_cnt++; fd_pos = i; end
      bi = i / BIT;
      if (bi > PRE && bi < PRE + 9 && (i % BIT) == H / 2) db[7 - (bi - PRE - 1)] = tx_out;
    end
    @(negedge clk);
    check_eq("wave_mism", wave_bad, 0);
    check_eq("busy_low_in_frame", busy_bad, 0);
    check_eq("done_count", fd_cnt, 1);
    check_eq("done_pos", fd_pos, FL - 1);
    check_eq("rx_byte", int'(db), int'(eb));
    check_eq("ready_after", int'(tx_ready), 1);
    check_eq("busy_after", int'(busy), 0);
    frames_seen++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx_out === 1'b1) capture();
    end
  end

  task automatic send(input logic [7:0] b, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    tx_data = b; tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check_eq("send_timeout", 1, 0);
    else if (push) exp_q.push_back(b);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (tx_ready !== 1'b1 && n < budget);
    if (tx_ready !== 1'b1) check_eq("idle_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_out, e_rdy, e_busy, e_done, n, f0, fd_cyc, acc_cyc;
    logic [7:0] rb;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check_eq("rst_out", int'(tx_out), 0);
    check_eq("rst_ready", int'(tx_ready), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(frame_done), 0);
    rst_n = 1'b1;

    // Idle line with no traffic.
    e_out = 0; e_rdy = 0; e_busy = 0; e_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_out !== 1'b0) e_out++;
      if (tx_ready !== 1'b1) e_rdy++;
      if (busy !== 1'b0) e_busy++;
      if (frame_done !== 1'b0) e_done++;
    end
    check_eq("idle_out", e_out, 0);
    check_eq("idle_ready", e_rdy, 0);
    check_eq("idle_busy", e_busy, 0);
    check_eq("idle_done", e_done, 0);

    mon_en = 1'b1;

    // Single frame 8'hA5.
    send(8'hA5, 1'b1);
    check_eq("busy_on_accept", int'(busy), 1);
    check_eq("ready_on_accept", int'(tx_ready), 0);
    wait_idle(FL + 50);

    // Back-to-back 00 then FF with tx_valid held.
    @(negedge clk);
    tx_data = 8'h00; tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    exp_q.push_back(8'h00);
    @(posedge clk); #1;
    tx_data = 8'hFF;
    fd_cyc = -1; n = 0;
    do begin
      @(negedge clk); n++;
      if (frame_done === 1'b1) fd_cyc = cyc;
    end while (!(tx_ready === 1'b1 && fd_cyc >= 0) && n < FL + 50);
    acc_cyc = cyc;
    exp_q.push_back(8'hFF);
    check_eq("b2b_spacing", acc_cyc - fd_cyc, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_idle(FL + 50);

    // Mid-frame tx_valid and tx_data change must be ignored.
    f0 = frames_seen;
    send(8'hA5, 1'b1);
    repeat (100) @(negedge clk);
    tx_data = 8'h3C; tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(FL + 50);
    repeat (20) @(negedge clk);
    check_eq("no_extra_frame", frames_seen - f0, 1);

    // Reset during DATA bit 3 (slot1 of a 0 bit, line high).
    mon_en = 1'b0;
    send(8'hA5, 1'b0);
    n = 0;
    while (tx_out !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat ((PRE + 1 + 3) * BIT + H + 2) @(negedge clk);
    check_eq("pre_rst_high", int'(tx_out), 1);
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst_out", int'(tx_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", int'(tx_ready), 1);
    check_eq("post_rst_busy", int'(busy), 0);
    check_eq("post_rst_out", int'(tx_out), 0);
    mon_en = 1'b1;
    send(8'h81, 1'b1);
    wait_idle(FL + 50);

    // Loopback of random bytes through the receiver model.
    for (int k = 0; k < 64; k++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb, 1'b1);
      wait_idle(FL + 50);
    end

    check_eq("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
